pix_threshold_detect: RTL

- Streaming stage directly upstream of the signal-inference block.
- Watches the background-subtracted pixel stream, counts pixels above a programmable threshold per frame, and emits the one-cycle HlsPixTh_tvalid event at end of frame when the hit count reaches a minimum.
- Passes the pixel stream through a one-deep register slice to the downstream DRAM/averaging path, unchanged.

---
 rtl/pix_threshold_detect_if.sv | 20 ++
 rtl/pix_threshold_detect.sv | 110 +++++++++++
 2 files changed

// File: rtl/pix_threshold_detect_if.sv
// Pixel stream handshake bundle: valid/ready, packed pixels, frame markers.
// tuser bit0 SOF, bit1 SOL, bit2 EOL, bit3 EOF.
interface pix_threshold_detect_if #(
  parameter int DATA_W = 64
) ();
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [3:0]        tuser;

  modport master (
    output tvalid, tdata, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tuser,
    output tready
  );
endinterface

// File: rtl/pix_threshold_detect.sv
// Per-frame above-threshold pixel counter with end-of-frame event,
// plus a one-deep register slice passing the stream through unchanged.
module pix_threshold_detect #(
  parameter int PIX_W        = 16,
  parameter int PIX_PER_BEAT = 4,
  parameter int CNT_W        = 24,
  parameter int FCNT_W       = 16
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              cfg_enable,
  input  logic [PIX_W-1:0]  cfg_threshold,
  input  logic [CNT_W-1:0]  cfg_min_hits,
  pix_threshold_detect_if.slave  s_axis,
  pix_threshold_detect_if.master m_axis,
  output logic              HlsPixTh_tvalid,
  output logic [CNT_W-1:0]  HlsPixTh_tdata,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              err_sof_in_frame
);

  localparam int HIT_W = $clog2(PIX_PER_BEAT + 1);

  typedef enum logic {
    IDLE,
    IN_FRAME
  } state_t;

  state_t state, state_nxt;

  logic             accept, sof, eof, in_frame;
  logic             count_en, done, fire, err_set;
  logic             en_q, en;
  logic [PIX_W-1:0] thr_q, thr;
  logic [CNT_W-1:0] min_q, min_h;
  logic [CNT_W-1:0] acc_q, acc_base, acc_sat;
  logic [CNT_W:0]   acc_sum;
  logic [HIT_W-1:0] hits;

  assign s_axis.tready = srst_n & (!m_axis.tvalid | m_axis.tready);
  assign accept   = s_axis.tvalid & s_axis.tready;
  assign sof      = s_axis.tuser[0];
  assign eof      = s_axis.tuser[3];
  assign in_frame = (state == IN_FRAME);

  always_ff @(posedge clk) begin
    if (!srst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept && eof)      state_nxt = IDLE;
    else if (accept && sof) state_nxt = IN_FRAME;
  end

  // An accepted SOF beat is judged against the config it latches.
  always_comb begin
    thr   = (accept && sof) ? cfg_threshold : thr_q;
    en    = (accept && sof) ? cfg_enable    : en_q;
    min_h = (accept && sof) ? cfg_min_hits  : min_q;
    hits  = '0;
    for (int k = 0; k < PIX_PER_BEAT; k++) begin
      if (s_axis.tdata[k*PIX_W +: PIX_W] > thr)
        hits = hits + HIT_W'(1);
    end
    acc_base = sof ? '0 : acc_q;
    acc_sum  = {1'b0, acc_base} + (CNT_W+1)'(hits);
    acc_sat  = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
    count_en = accept & (sof | in_frame);
    done     = accept & eof & (sof | in_frame);
    fire     = done & en & (acc_sat >= min_h);
    err_set  = accept & sof & in_frame;
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      m_axis.tvalid    <= 1'b0;
      m_axis.tdata     <= '0;
      m_axis.tuser     <= '0;
      acc_q            <= '0;
      thr_q            <= '0;
      en_q             <= 1'b0;
      min_q            <= '0;
      HlsPixTh_tvalid  <= 1'b0;
      HlsPixTh_tdata   <= '0;
      frame_cnt        <= '0;
      err_sof_in_frame <= 1'b0;
    end else begin
      if (accept) begin
        m_axis.tvalid <= 1'b1;
        m_axis.tdata  <= s_axis.tdata;
        m_axis.tuser  <= s_axis.tuser;
      end else if (m_axis.tready) begin
        m_axis.tvalid <= 1'b0;
      end
      if (count_en) acc_q <= acc_sat;
      if (accept && sof) begin
        thr_q <= cfg_threshold;
        en_q  <= cfg_enable;
        min_q <= cfg_min_hits;
      end
      HlsPixTh_tvalid <= fire;
      if (fire)    HlsPixTh_tdata   <= acc_sat;
      if (done)    frame_cnt        <= frame_cnt + FCNT_W'(1);
      if (err_set) err_sof_in_frame <= 1'b1;
    end
  end

endmodule
